delay_tap_ctrl: RTL and testbench
=================================

DELAY_TAP_CTRL -- requirements
Module: delay_tap_ctrl

Interface
REQ-001: Parameter DEFAULT_TAP, 0, tap index the delay line holds after a load (0..MAX_TAP).
REQ-002: Parameter MAX_TAP, 127, highest legal tap index.
REQ-003: Parameter SETTLE_CYCLES, 4, idle cycles after each MOVE pulse (range 1..15).
REQ-004: CLK  input  1  sole clock; all logic on rising edge.
REQ-005: RSTN  input  1  reset, synchronous, active-low.
REQ-006: REQ_VALID  input  1  tap-change request present.
REQ-007: REQ_READY  output  1  controller can accept a request.
REQ-008: REQ_TAP  input  7  target tap index.
REQ-009: REQ_LOAD  input  1  reload line to DEFAULT_TAP before stepping.
REQ-010: LOADN  output  1  active-low load strobe to the dynamic delay line.
REQ-011: MOVE  output  1  one-cycle step pulse to the delay line.
REQ-012: DIRECTION  output  1  step direction: 0 = increment tap, 1 = decrement tap.
REQ-013: CFLAG  input  1  delay line reports it is at a tap limit.
REQ-014: CUR_TAP  output  7  tap index the controller believes is applied.
REQ-015: DONE  output  1  one-cycle pulse on request completion.
REQ-016: ERR  output  1  last request aborted on CFLAG or was clamped.

Function
REQ-017: FSM states SHALL be INIT_LOAD, IDLE, LOAD, STEP, SETTLE, FINISH.
REQ-018: REQ_READY SHALL be 1 only in IDLE; a request is accepted on a cycle with REQ_VALID=1 and REQ_READY=1.
REQ-019: On acceptance, REQ_TAP SHALL be captured into a target register, clamped to MAX_TAP; clamping sets ERR.
REQ-020: ERR SHALL clear on each accepted request (then set per REQ-019/REQ-026) and otherwise hold.
REQ-021: IDLE -> LOAD on acceptance with REQ_LOAD=1; IDLE -> STEP if target != CUR_TAP; IDLE -> FINISH if target == CUR_TAP.
REQ-022: LOAD and INIT_LOAD SHALL drive LOADN=0 for exactly 2 cycles, then set CUR_TAP=DEFAULT_TAP.
REQ-023: After LOAD: -> STEP if target != DEFAULT_TAP, else -> FINISH.
REQ-024: STEP SHALL last 1 cycle with MOVE=1, DIRECTION=(target < CUR_TAP), and update CUR_TAP by +/-1 at the end of that cycle.
REQ-025: DIRECTION SHALL be stable from the cycle before MOVE rises through SETTLE; MOVE=0 in all states except STEP.
REQ-026: CFLAG=1 sampled in STEP SHALL suppress the CUR_TAP update, set ERR, and go to FINISH.
REQ-027: SETTLE SHALL last SETTLE_CYCLES cycles, then -> STEP if CUR_TAP != target, else -> FINISH.
REQ-028: FINISH SHALL last 1 cycle with DONE=1, then -> IDLE.
REQ-029: Latency accept-to-DONE: N steps = N*(1+SETTLE_CYCLES)+1 cycles; add 2 with REQ_LOAD; 0 steps = 1 cycle.
REQ-030: CUR_TAP SHALL never wrap below 0 or above MAX_TAP.
REQ-031: REQ_VALID while busy SHALL be ignored (no queueing); REQ_TAP/REQ_LOAD are only sampled on acceptance.

Reset
REQ-032: RSTN=0 at a rising edge SHALL force INIT_LOAD regardless of state, including mid-STEP/SETTLE.
REQ-033: Reset values: REQ_READY=0, LOADN=1, MOVE=0, DIRECTION=0, CUR_TAP=DEFAULT_TAP, DONE=0, ERR=0.
REQ-034: After RSTN deasserts, INIT_LOAD SHALL drive LOADN=0 for 2 cycles then enter IDLE without pulsing DONE, so line and CUR_TAP agree.

Verification
REQ-035: Release reset -> LOADN low cycles 1-2, REQ_READY=1 from cycle 3, CUR_TAP=0, DONE never pulses.
REQ-036: From tap 0, request REQ_TAP=3, SETTLE_CYCLES=4 -> 3 MOVE pulses 5 cycles apart, DIRECTION=0, CUR_TAP=3, DONE 16 cycles after accept.
REQ-037: From tap 3, request REQ_TAP=1 with REQ_LOAD=1 -> LOADN low 2 cycles, CUR_TAP=0, 1 MOVE with DIRECTION=0, CUR_TAP=1, DONE.
REQ-038: From tap 5, request REQ_TAP=9, CFLAG=1 during 2nd STEP -> CUR_TAP=6, ERR=1, DONE next cycle, no further MOVE.
REQ-039: Request REQ_TAP=5 at CUR_TAP=5 -> DONE 1 cycle after accept, no MOVE, ERR=0; REQ_VALID pulses while busy are not accepted.
REQ-040: RSTN low during SETTLE of a 0->10 request -> MOVE=0 immediately, INIT_LOAD re-runs, CUR_TAP=0, no DONE.

Source files
------------

// File: rtl/delay_tap_ctrl.sv
// Tap controller for a dynamic delay line: loads DEFAULT_TAP and steps the line one tap at a time to a requested index.
// Latency accept-to-done: N*(1+SETTLE_CYCLES)+1 cycles for N steps, +2 when a reload is requested, 1 cycle for zero steps.
// Backpressure: req_ready is high only while idle; req_valid while busy is ignored (nothing queued).
module delay_tap_ctrl #(
    parameter int DEFAULT_TAP   = 0,
    parameter int MAX_TAP       = 127,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [6:0] req_tap,
    input  logic       req_load,
    output logic       loadn,
    output logic       move,
    output logic       direction,
    input  logic       cflag,
    output logic [6:0] cur_tap,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        INIT_LOAD,
        IDLE,
        LOAD,
        STEP,
        SETTLE,
        FINISH
    } state_t;

    localparam logic [6:0] DEF_T       = 7'(DEFAULT_TAP);
    localparam logic [6:0] MAX_T       = 7'(MAX_TAP);
    localparam logic [7:0] MAX_T8      = 8'(MAX_TAP);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    // Load strobe is two cycles long; INIT_LOAD spends its cnt==0 cycle
    // held in reset with the strobe inactive, so it ends one count later.
    localparam logic [3:0] LOAD_LAST   = 4'd1;
    localparam logic [3:0] INIT_LAST   = 4'd2;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic [6:0] target_q;

    logic       accept;
    logic       clamp_hit;
    logic [6:0] tap_in;
    logic [6:0] dir_ref;

    // Next-state decode and state-derived strobes
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        loadn     = 1'b1;
        move      = 1'b0;
        done      = 1'b0;

        clamp_hit = ({1'b0, req_tap} > MAX_T8);
        tap_in    = clamp_hit ? MAX_T : req_tap;
        // With a reload the first step starts from the default tap, so the
        // direction is decided against that rather than the current tap.
        dir_ref   = req_load ? DEF_T : cur_tap;

        case (state_q)
            INIT_LOAD: begin
                loadn = (cnt_q == 4'd0);
                if (cnt_q == INIT_LAST) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                req_ready = 1'b1;
            end
            LOAD: begin
                loadn = 1'b0;
                if (cnt_q == LOAD_LAST) begin
                    state_d = (target_q != DEF_T) ? STEP : FINISH;
                end
            end
            STEP: begin
                move    = 1'b1;
                state_d = cflag ? FINISH : SETTLE;
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = (cur_tap != target_q) ? STEP : FINISH;
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = INIT_LOAD;
            end
        endcase

        accept = req_valid && req_ready;
        if (accept) begin
            if (req_load) begin
                state_d = LOAD;
            end else if (tap_in != cur_tap) begin
                state_d = STEP;
            end else begin
                state_d = FINISH;
            end
        end

        // Per-state dwell counter restarts on every state change
        cnt_d = (state_d == state_q) ? (cnt_q + 4'd1) : 4'd0;
    end

    // State register and dwell counter
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= INIT_LOAD;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request capture, direction, error flag and tap tracking
    always_ff @(posedge clk) begin
        if (!rstn) begin
            target_q  <= DEF_T;
            direction <= 1'b0;
            err       <= 1'b0;
            cur_tap   <= DEF_T;
        end else begin
            if (accept) begin
                target_q  <= tap_in;
                err       <= clamp_hit;
                // Direction is fixed for the whole request: stepping is
                // monotonic toward the target, so it never needs to flip.
                direction <= (tap_in < dir_ref);
            end

            if ((state_q == INIT_LOAD) && (cnt_q == INIT_LAST)) begin
                cur_tap <= DEF_T;
            end

            if ((state_q == LOAD) && (cnt_q == LOAD_LAST)) begin
                cur_tap <= DEF_T;
            end

            if (state_q == STEP) begin
                if (cflag) begin
                    err <= 1'b1;
                end else if (direction) begin
                    if (cur_tap != 7'd0) begin
                        cur_tap <= cur_tap - 7'd1;
                    end
                end else begin
                    if (cur_tap != MAX_T) begin
                        cur_tap <= cur_tap + 7'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_delay_tap_ctrl.sv
// Bench for delay_tap_ctrl: scoreboard of expected request outcomes checked when done pulses.
// Latency, move count/spacing, load strobe length, tap and error flag checked per request.
// Busy-time req_valid noise exercises the no-queueing behaviour.
module tb_delay_tap_ctrl;

    localparam int DEF  = 0;
    localparam int MAXT = 127;
    localparam int S    = 4;

    logic       clk;
    logic       rstn;
    logic       req_valid;
    logic       req_ready;
    logic [6:0] req_tap;
    logic       req_load;
    logic       loadn;
    logic       move;
    logic       direction;
    logic       cflag;
    logic [6:0] cur_tap;
    logic       done;
    logic       err;

    delay_tap_ctrl #(
        .DEFAULT_TAP  (DEF),
        .MAX_TAP      (MAXT),
        .SETTLE_CYCLES(S)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_tap  (req_tap),
        .req_load (req_load),
        .loadn    (loadn),
        .move     (move),
        .direction(direction),
        .cflag    (cflag),
        .cur_tap  (cur_tap),
        .done     (done),
        .err      (err)
    );

    typedef struct {
        int tap;
        int err;
        int lat;
        int moves;
        int loads;
        int dir;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;
    int model_tap = DEF;

    // monitor state
    bit   busy = 0;
    int   cyc;
    int   mv;
    int   ld;
    int   last_mv;
    exp_t mon_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitor: tracks the accepted request and compares on done
    always @(negedge clk) begin
        if (!rstn) begin
            busy = 0;
        end else begin
            if (busy) begin
                cyc++;
                if (req_valid) check_val("ready_while_busy", req_ready, 0);
                if (move) begin
                    mv++;
                    if (sb.size() > 0) check_val("direction", direction, sb[0].dir);
                    if (mv > 1) check_val("move_gap", cyc - last_mv, S + 1);
                    last_mv = cyc;
                end
                if (!loadn) ld++;
                if (done) begin
                    if (sb.size() == 0) begin
                        check_val("sb_underflow", sb.size(), 1);
                    end else begin
                        mon_e = sb.pop_front();
                        check_val("latency", cyc, mon_e.lat);
                        check_val("cur_tap", cur_tap, mon_e.tap);
                        check_val("err", err, mon_e.err);
                        check_val("moves", mv, mon_e.moves);
                        check_val("load_cycles", ld, mon_e.loads);
                    end
                    busy = 0;
                end
            end else if (done) begin
                check_val("stray_done", done, 0);
            end
            if (req_valid && req_ready) begin
                busy    = 1;
                cyc     = 0;
                mv      = 0;
                ld      = 0;
                last_mv = 0;
            end
        end
    end

    // Hold reset, check reset values, release and check the init load sequence
    task automatic do_reset();
        rstn      = 1'b0;
        req_valid = 1'b0;
        req_load  = 1'b0;
        req_tap   = 7'd0;
        cflag     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_loadn", loadn, 1);
        check_val("rst_ready", req_ready, 0);
        check_val("rst_move", move, 0);
        check_val("rst_done", done, 0);
        check_val("rst_dir", direction, 0);
        check_val("rst_err", err, 0);
        check_val("rst_cur_tap", cur_tap, DEF);
        rstn = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            #1;
            check_val("init_loadn", loadn, (c <= 2) ? 0 : 1);
            check_val("init_ready", req_ready, (c == 3) ? 1 : 0);
            check_val("init_cur_tap", cur_tap, DEF);
        end
        model_tap = DEF;
    endtask

    // Issue one request, push its expected outcome, wait for done
    task automatic do_req(input int tap, input bit load, input int abort_k, input bit noise);
        exp_t e;
        int   start;
        int   n;
        int   mc;
        bit   acc;
        bit   got;
        start   = load ? DEF : model_tap;
        n       = (tap > start) ? (tap - start) : (start - tap);
        e.dir   = (tap < start) ? 1 : 0;
        e.loads = load ? 2 : 0;
        if (abort_k > 0 && abort_k <= n) begin
            e.moves = abort_k;
            e.tap   = e.dir ? (start - (abort_k - 1)) : (start + (abort_k - 1));
            e.err   = 1;
            e.lat   = (abort_k - 1) * (S + 1) + 2 + e.loads;
        end else begin
            e.moves = n;
            e.tap   = tap;
            e.err   = 0;
            e.lat   = n * (S + 1) + 1 + e.loads;
        end
        sb.push_back(e);

        req_tap   = 7'(tap);
        req_load  = load;
        req_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 50; i++) begin
            if (req_ready) begin
                acc = 1;
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        req_tap   = 7'($urandom);
        req_load  = 1'($urandom);
        if (!acc) check_val("accept_timeout", 0, 1);

        mc  = 0;
        got = 0;
        for (int c = 0; c < 2000; c++) begin
            if (done) begin
                got = 1;
                break;
            end
            if (move) begin
                mc++;
                cflag = (mc == abort_k);
            end else begin
                cflag = 1'b0;
            end
            if (noise) begin
                req_valid = 1'($urandom);
                req_tap   = 7'($urandom);
                req_load  = 1'($urandom);
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        cflag     = 1'b0;
        if (!got) check_val("done_timeout", 0, 1);
        @(posedge clk);
        #1;
        model_tap = e.tap;
    endtask

    initial begin
        rstn      = 1'b0;
        req_valid = 1'b0;
        req_tap   = 7'd0;
        req_load  = 1'b0;
        cflag     = 1'b0;

        do_reset();

        do_req(3, 0, 0, 0);   // three up-steps from tap 0
        do_req(1, 1, 0, 0);   // reload, then one up-step
        do_req(5, 0, 0, 0);
        do_req(9, 0, 2, 0);   // limit flag on the second step
        do_req(5, 0, 0, 0);   // one down-step
        do_req(5, 0, 0, 1);   // zero steps, error clears, noise ignored
        do_req(2, 0, 0, 1);   // down-steps with busy-time noise
        do_req(0, 1, 0, 0);   // reload straight to the target
        do_req(MAXT, 0, 0, 0); // full range to the top tap
        do_req(MAXT - 1, 0, 1, 0); // abort on first down-step at the top
        do_req(4, 1, 0, 1);
        for (int i = 0; i < 4; i++) begin
            do_req($urandom_range(0, 12), 1'($urandom_range(0, 1)), 0, 1);
        end

        // Reset in the middle of a 0->10 request, while settling
        do_req(0, 1, 0, 0);
        req_tap   = 7'd10;
        req_load  = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_val("mid_settle_tap", cur_tap, 2);
        check_val("mid_settle_move", move, 0);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check_val("abort_rst_move", move, 0);
        check_val("abort_rst_tap", cur_tap, DEF);
        check_val("abort_rst_loadn", loadn, 1);
        check_val("abort_rst_ready", req_ready, 0);
        do_reset();
        do_req(2, 0, 0, 0);

        repeat (5) @(posedge clk);
        check_val("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, got %0d pending expected 0", sb.size());
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

endmodule
